// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//  - fetch_state_t : sequencer FSM states
//  - INSTR_W/LINE_W: instruction and memory-line widths
//  - RV opcode constants shared with the decode stage
//  - is_zero_instr : all-zero instruction detect, used as the halt marker
package fetch_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam int LINE_W  = 64;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ISSUE,
        HALT
    } fetch_state_t;

    // RV64IM major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic is_zero_instr(input logic [INSTR_W-1:0] word);
        return word == '0;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory-port and decode-port signals of the fetch sequencer.
//  req_valid/req_addr/req_ready : line request handshake (sequencer -> memory)
//  resp_valid/resp_data         : one-cycle line response (memory -> sequencer)
//  dec_valid/dec_instr/dec_pc/dec_ready : instruction handshake (sequencer -> decoder)
// Modport master is the sequencer side, slave the memory/decoder side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [63:0]       resp_data;
    logic              dec_valid;
    logic [31:0]       dec_instr;
    logic [ADDR_W-1:0] dec_pc;
    logic              dec_ready;

    modport master (
        output req_valid, req_addr, dec_valid, dec_instr, dec_pc,
        input  req_ready, resp_valid, resp_data, dec_ready
    );

    modport slave (
        input  req_valid, req_addr, dec_valid, dec_instr, dec_pc,
        output req_ready, resp_valid, resp_data, dec_ready
    );
endinterface

// File: rtl/fetch_sequencer_line_buf.sv
// Holds the most recently fetched 64-bit line and selects one 32-bit half.
//  clk       in  : clock
//  load      in  : capture line_in on this edge
//  line_in   in  : line from memory ([31:0] = PC+0, [63:32] = PC+4)
//  sel       in  : 0 lower word, 1 upper word
//  word      out : selected instruction word
//  word_zero out : selected word is all zero
module fetch_sequencer_line_buf
    import fetch_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               load,
    input  logic [LINE_W-1:0]  line_in,
    input  logic               sel,
    output logic [INSTR_W-1:0] word,
    output logic               word_zero
);
    // Data-only register: it is always reloaded before being read.
    logic [LINE_W-1:0] line;

    always_ff @(posedge clk) begin
        if (load) begin
            line <= line_in;
        end
    end

    assign word      = sel ? line[LINE_W-1:INSTR_W] : line[INSTR_W-1:0];
    assign word_zero = is_zero_instr(word);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: requests 64-bit lines one at a time, splits each into two
// 32-bit instructions and hands them to the decoder in PC order.
//  clk, reset          : clock, synchronous active-high reset
//  start, entry_pc     : begin fetching at entry_pc (from IDLE/HALT)
//  bus (master)        : memory request/response and decoder handshake
//  redirect_valid/_pc  : flush and refetch from redirect_pc
//  halted              : sticky, set when an all-zero instruction is reached
//  issue_count         : instructions accepted by the decoder (wraps)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter bit HALT_ON_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] entry_pc,
    fetch_sequencer_if.master bus,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [31:0]       issue_count
);
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);

    fetch_state_t       state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic               drop, drop_next;
    logic               halted_next;
    logic [31:0]        count_next;
    logic               dec_valid_next;
    logic [31:0]        dec_instr_next;
    logic [ADDR_W-1:0]  dec_pc_next;

    logic               line_load;
    logic               buf_sel;
    logic [INSTR_W-1:0] word;
    logic               word_zero;
    logic               redirect_active;
    logic               req_fire;
    logic               dec_accept;

    // While an instruction is held, the only next word that can be needed
    // is the upper half of the same line.
    assign buf_sel = bus.dec_valid ? 1'b1 : pc[2];

    fetch_sequencer_line_buf u_line_buf (
        .clk       (clk),
        .load      (line_load),
        .line_in   (bus.resp_data),
        .sel       (buf_sel),
        .word      (word),
        .word_zero (word_zero)
    );

    assign redirect_active = redirect_valid &&
                             (state == REQ || state == WAIT || state == ISSUE);
    assign req_fire        = bus.req_valid && bus.req_ready;
    assign dec_accept      = bus.dec_valid && bus.dec_ready;
    assign line_load       = (state == WAIT) && bus.resp_valid && !drop && !redirect_active;

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        drop_next      = drop;
        halted_next    = halted;
        count_next     = issue_count;
        dec_valid_next = bus.dec_valid;
        dec_instr_next = bus.dec_instr;
        dec_pc_next    = bus.dec_pc;

        // An accepted instruction counts even if a redirect lands this cycle.
        if (dec_accept) begin
            count_next = issue_count + 32'd1;
        end

        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_next     = entry_pc & PC_MASK;
                    halted_next = 1'b0;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.resp_valid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!bus.dec_valid) begin
                    // Freshly captured line: present the half selected by pc[2].
                    if (word_zero && HALT_ON_ZERO) begin
                        halted_next = 1'b1;
                        state_next  = HALT;
                    end else begin
                        dec_valid_next = 1'b1;
                        dec_instr_next = word;
                        dec_pc_next    = pc;
                    end
                end else if (bus.dec_ready) begin
                    pc_next = pc + ADDR_W'(4);
                    if (!pc[2]) begin
                        // Lower half accepted: upper half follows with no bubble.
                        if (word_zero && HALT_ON_ZERO) begin
                            dec_valid_next = 1'b0;
                            halted_next    = 1'b1;
                            state_next     = HALT;
                        end else begin
                            dec_instr_next = word;
                            dec_pc_next    = pc + ADDR_W'(4);
                        end
                    end else begin
                        dec_valid_next = 1'b0;
                        state_next     = REQ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect_active) begin
            pc_next        = redirect_pc & PC_MASK;
            dec_valid_next = 1'b0;
            halted_next    = halted;
            state_next     = REQ;
            // A request left outstanding must have its response discarded. In
            // WAIT, a response arriving this very cycle retires it instead.
            if (state == WAIT) begin
                drop_next = !bus.resp_valid;
            end else if (state == REQ && req_fire) begin
                drop_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= '0;
            drop          <= 1'b0;
            halted        <= 1'b0;
            issue_count   <= '0;
            bus.req_valid <= 1'b0;
            bus.req_addr  <= '0;
            bus.dec_valid <= 1'b0;
            bus.dec_instr <= '0;
            bus.dec_pc    <= '0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            drop          <= drop_next;
            halted        <= halted_next;
            issue_count   <= count_next;
            bus.dec_valid <= dec_valid_next;
            bus.dec_instr <= dec_instr_next;
            bus.dec_pc    <= dec_pc_next;
            bus.req_valid <= (state_next == REQ);
            if (state_next == REQ) begin
                bus.req_addr <= {pc_next[ADDR_W-1:3], 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] entry_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;
    logic [31:0]       issue_count;

    fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(.ADDR_W(ADDR_W), .HALT_ON_ZERO(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .entry_pc       (entry_pc),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .issue_count    (issue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Scoreboard: every accepted instruction must match the next expectation.
    always @(negedge clk) begin
        if (!reset && bus.dec_valid && bus.dec_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", bus.dec_pc, 64'hffff_ffff_ffff_ffff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_pc", bus.dec_pc, e.pc);
                check("issue_instr", {32'h0, bus.dec_instr}, {32'h0, e.instr});
            end
        end
    end

    task automatic push_exp(input logic [63:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        start          = 1'b0;
        entry_pc       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.dec_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start(input logic [63:0] pc);
        entry_pc = pc;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for a request, check its address, let the handshake edge pass.
    task automatic wait_req(input string tag, input logic [63:0] want);
        int n = 0;
        @(negedge clk);
        while (!bus.req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.req_valid ? bus.req_addr : 64'hdead_0000_0000_0000, want);
        @(posedge clk);
        #1;
    endtask

    task automatic give_resp(input logic [63:0] data);
        repeat (2) @(posedge clk);
        #1;
        bus.resp_valid = 1'b1;
        bus.resp_data  = data;
        @(posedge clk);
        #1 bus.resp_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_req_valid", {63'h0, bus.req_valid}, 64'd0);
        check("rst_req_addr", bus.req_addr, 64'd0);
        check("rst_dec_valid", {63'h0, bus.dec_valid}, 64'd0);
        check("rst_dec_instr", {32'h0, bus.dec_instr}, 64'd0);
        check("rst_dec_pc", bus.dec_pc, 64'd0);
        check("rst_halted", {63'h0, halted}, 64'd0);
        check("rst_count", {32'h0, issue_count}, 64'd0);
        @(posedge clk);
        #1;

        // 1. Aligned line, both halves issued in order
        push_exp(64'h1000, 32'h00100093);
        push_exp(64'h1004, 32'h00500113);
        pulse_start(64'h1000);
        wait_req("t1_req_addr", 64'h1000);
        give_resp(64'h00500113_00100093);
        wait_drain();
        wait_req("t1_next_req", 64'h1008);
        check("t1_count", {32'h0, issue_count}, 64'd2);

        // 2. Unaligned entry: only the upper half
        do_reset();
        push_exp(64'h1004, 32'h12345678);
        pulse_start(64'h1006);
        wait_req("t2_req_addr", 64'h1000);
        give_resp(64'h12345678_9abcdef0);
        wait_drain();
        wait_req("t2_next_req", 64'h1008);
        check("t2_count", {32'h0, issue_count}, 64'd1);

        // 3. Decoder stall holds the presented instruction
        do_reset();
        bus.dec_ready = 1'b0;
        push_exp(64'h1000, 32'h00100093);
        push_exp(64'h1004, 32'h00500113);
        pulse_start(64'h1000);
        wait_req("t3_req_addr", 64'h1000);
        give_resp(64'h00500113_00100093);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus.dec_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", {63'h0, bus.dec_valid}, 64'd1);
            check("t3_hold_instr", {32'h0, bus.dec_instr}, 64'h00100093);
            check("t3_hold_pc", bus.dec_pc, 64'h1000);
            check("t3_hold_count", {32'h0, issue_count}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.dec_ready = 1'b1;
        wait_drain();
        check("t3_count", {32'h0, issue_count}, 64'd2);

        // 4. Zero upper word halts fetch
        do_reset();
        push_exp(64'h1000, 32'h00100093);
        pulse_start(64'h1000);
        wait_req("t4_req_addr", 64'h1000);
        give_resp(64'h00000000_00100093);
        wait_drain();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_halted", {63'h0, halted}, 64'd1);
            check("t4_no_req", {63'h0, bus.req_valid}, 64'd0);
            check("t4_no_dec", {63'h0, bus.dec_valid}, 64'd0);
        end
        check("t4_count", {32'h0, issue_count}, 64'd1);
        @(posedge clk);
        #1;

        // 5. Redirect in WAIT drops the stale response
        do_reset();
        push_exp(64'h2000, 32'h00000013);
        push_exp(64'h2004, 32'h00a00513);
        pulse_start(64'h1000);
        wait_req("t5_req_addr", 64'h1000);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_req("t5_redir_req", 64'h2000);
        give_resp(64'hdeadbeef_cafef00d);
        wait_req("t5_refetch", 64'h2000);
        give_resp(64'h00a00513_00000013);
        wait_drain();
        check("t5_count", {32'h0, issue_count}, 64'd2);

        // 6. Reset while an instruction is presented
        do_reset();
        bus.dec_ready = 1'b0;
        pulse_start(64'h1000);
        wait_req("t6_req_addr", 64'h1000);
        give_resp(64'h00500113_00100093);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus.dec_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t6_pre_valid", {63'h0, bus.dec_valid}, 64'd1);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t6_req_valid", {63'h0, bus.req_valid}, 64'd0);
        check("t6_req_addr", bus.req_addr, 64'd0);
        check("t6_dec_valid", {63'h0, bus.dec_valid}, 64'd0);
        check("t6_dec_instr", {32'h0, bus.dec_instr}, 64'd0);
        check("t6_dec_pc", bus.dec_pc, 64'd0);
        check("t6_count", {32'h0, issue_count}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 64'h11111111_22222222;
        @(posedge clk);
        #1 bus.resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_idle_req", {63'h0, bus.req_valid}, 64'd0);
            check("t6_idle_dec", {63'h0, bus.dec_valid}, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
